// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster pixel stream: two line buffers, a products stage, then an adder-tree stage.
// Optional build macro CONV3X3_RELU_EN clamps negative results to zero in the second stage.
module conv3x3_stream #(
    parameter  int IMG_W  = 16,
    parameter  int IMG_H  = 16,
    parameter  int DATA_W = 8,
    parameter  int COEF_W = 8,
    localparam int ACC_W  = DATA_W + COEF_W + 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       pxl_in,
    input  logic                    pxl_valid,
    input  logic                    sof,
    input  logic [9*COEF_W-1:0]     kernel,
    output logic signed [ACC_W-1:0] pxl_out,
    output logic                    out_valid,
    output logic                    out_last
);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col_reg, col_next, cur_col, rd_addr;
    logic [RW-1:0] row_reg, row_next, cur_row;

    // sof relocates the current pixel to the frame origin regardless of the counters
    always_comb begin
        cur_col  = sof ? '0 : col_reg;
        cur_row  = sof ? '0 : row_reg;
        col_next = col_reg;
        row_next = row_reg;
        if (pxl_valid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_next = '0;
                row_next = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_next = cur_col + 1'b1;
                row_next = cur_row;
            end
        end
        rd_addr = reset ? '0 : col_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // Line buffers are read one column ahead so the registered read data lines up with the
    // next accepted pixel. A sof mid-row mispredicts only data that row 0 never consumes.
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] lb2_mem [IMG_W];
    logic [DATA_W-1:0] lb1_rd_reg, lb2_rd_reg;

    always_ff @(posedge clk) begin
        lb1_rd_reg <= lb1_mem[rd_addr];
        lb2_rd_reg <= lb2_mem[rd_addr];
        if (pxl_valid && !reset) begin
            lb1_mem[cur_col] <= pxl_in;
            lb2_mem[cur_col] <= lb1_rd_reg;
        end
    end

    logic [9*COEF_W-1:0] kernel_reg;
    logic                kcap_pend_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            kernel_reg    <= '0;
            kcap_pend_reg <= 1'b1;
        end else if (pxl_valid) begin
            if (sof || kcap_pend_reg) begin
                kernel_reg <= kernel;
            end
            kcap_pend_reg <= 1'b0;
        end
    end

    // Window columns: c0 = col-2, c1 = col-1, new_col = col; index 0 is row-2
    logic [DATA_W-1:0] new_col [3];
    logic [DATA_W-1:0] c0_reg  [3];
    logic [DATA_W-1:0] c1_reg  [3];
    logic [DATA_W-1:0] win     [9];

    assign new_col[0] = lb2_rd_reg;
    assign new_col[1] = lb1_rd_reg;
    assign new_col[2] = pxl_in;

    always_ff @(posedge clk) begin
        if (pxl_valid) begin
            for (int i = 0; i < 3; i++) begin
                c0_reg[i] <= c1_reg[i];
                c1_reg[i] <= new_col[i];
            end
        end
    end

    logic signed [PROD_W-1:0] prod_comb [9];
    logic signed [PROD_W-1:0] prod_reg  [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            logic signed [COEF_W-1:0] coef;
            logic signed [PROD_W-1:0] coef_ext;
            logic signed [PROD_W-1:0] pix_ext;

            if (gi % 3 == 0) begin : g_c0
                assign win[gi] = c0_reg[gi/3];
            end else if (gi % 3 == 1) begin : g_c1
                assign win[gi] = c1_reg[gi/3];
            end else begin : g_c2
                assign win[gi] = new_col[gi/3];
            end

            assign coef          = kernel_reg[gi*COEF_W +: COEF_W];
            assign coef_ext      = PROD_W'(coef);
            assign pix_ext       = PROD_W'(win[gi]);
            assign prod_comb[gi] = coef_ext * pix_ext;
        end
    endgenerate

    logic s1_valid_reg, s1_last_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= pxl_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            s1_last_reg  <= pxl_valid && (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (pxl_valid) begin
            for (int i = 0; i < 9; i++) begin
                prod_reg[i] <= prod_comb[i];
            end
        end
    end

    logic signed [ACC_W-1:0] acc_sum, result;

    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < 9; i++) begin
            acc_sum = acc_sum + ACC_W'(prod_reg[i]);
        end
`ifdef CONV3X3_RELU_EN
        result = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
        result = acc_sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pxl_out   <= '0;
        end else begin
            out_valid <= s1_valid_reg;
            out_last  <= s1_valid_reg && s1_last_reg;
            if (s1_valid_reg) begin
                pxl_out <= result;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on a 5x5 frame; expected results come from a frame-array model.
module tb_conv3x3_stream;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int AW = 21;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           pxl_in;
    logic                 pxl_valid;
    logic                 sof;
    logic [71:0]          kernel;
    logic signed [AW-1:0] pxl_out;
    logic                 out_valid;
    logic                 out_last;

    always #5 clk = ~clk;

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .COEF_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pxl_in    (pxl_in),
        .pxl_valid (pxl_valid),
        .sof       (sof),
        .kernel    (kernel),
        .pxl_out   (pxl_out),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    typedef struct {
        logic signed [AW-1:0] val;
        bit                   last;
        int                   due;
    } exp_t;

    exp_t                 q[$];
    exp_t                 mon_e;
    int                   cyc = 0;
    int                   n_checks = 0;
    int                   n_fail = 0;
    int                   pulse_cnt = 0;
    int                   last_cnt = 0;
    bit                   mon_en = 0;
    logic signed [AW-1:0] hold_exp = '0;

    int                   mrow, mcol;
    bit                   kpend;
    logic [71:0]          mk;
    logic [71:0]          kern_drv;
    int                   img [H][W];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every cycle either the next expected result is due or the outputs must be idle
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL result_valid cyc %0d: got out_valid=%b expected 1", cyc, out_valid);
                end else begin
                    n_checks += 2;
                    if (pxl_out !== mon_e.val) begin
                        n_fail++;
                        $display("FAIL result_value cyc %0d: got %0d expected %0d", cyc, pxl_out, mon_e.val);
                    end
                    if (out_last !== mon_e.last) begin
                        n_fail++;
                        $display("FAIL result_last cyc %0d: got %b expected %b", cyc, out_last, mon_e.last);
                    end
                end
                hold_exp = mon_e.val;
            end else begin
                n_checks += 2;
                if (out_valid !== 1'b0 || out_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs cyc %0d: got valid=%b last=%b expected 0 0", cyc, out_valid, out_last);
                end
                if (pxl_out !== hold_exp) begin
                    n_fail++;
                    $display("FAIL hold_value cyc %0d: got %0d expected %0d", cyc, pxl_out, hold_exp);
                end
            end
            if (out_valid === 1'b1) begin
                pulse_cnt++;
                if (out_last === 1'b1) last_cnt++;
                $display("result %0d last %b at cycle %0d", pxl_out, out_last, cyc);
            end
        end
    end

    function automatic int coef(input logic [71:0] k, input int idx);
        logic signed [7:0] c;
        c = k[idx*8 +: 8];
        return int'(c);
    endfunction

    function automatic logic [71:0] kern_all(input logic [7:0] c);
        logic [71:0] k;
        for (int i = 0; i < 9; i++) k[i*8 +: 8] = c;
        return k;
    endfunction

    function automatic logic [71:0] kern_rand();
        logic [71:0] k;
        for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'($urandom_range(0, 255));
        return k;
    endfunction

    task automatic model_accept(input bit s, input logic [7:0] p);
        int sum;
        if (s) begin
            mrow = 0;
            mcol = 0;
        end
        if (s || kpend) begin
            mk    = kern_drv;
            kpend = 0;
        end
        img[mrow][mcol] = int'(p);
        if (mrow >= 2 && mcol >= 2) begin
            sum = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    sum += coef(mk, i*3 + j) * img[mrow-2+i][mcol-2+j];
`ifdef CONV3X3_RELU_EN
            if (sum < 0) sum = 0;
`endif
            q.push_back('{val: AW'(sum), last: (mrow == H-1 && mcol == W-1), due: cyc + 2});
        end
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
        end
    endtask

    // Called just after a rising edge; the pixel is accepted at the next edge
    task automatic drive(input bit v, input bit s, input logic [7:0] p);
        pxl_valid = v;
        sof       = s & v;
        pxl_in    = p;
        kernel    = kern_drv;
        if (v) model_accept(s, p);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        pxl_valid = 1'b0;
        sof       = 1'b0;
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        mrow  = 0;
        mcol  = 0;
        kpend = 1;
        @(posedge clk);
        #1;
        hold_exp = '0;
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic ramp(input int n, input bit with_sof);
        for (int i = 0; i < n; i++) drive(1'b1, with_sof && i == 0, 8'(i));
    endtask

    task automatic drain();
        repeat (4) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        kern_drv = kern_rand();
        do_reset(3);
        n_checks += 3;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        if (out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_last: got %b expected 0", out_last);
        end
        if (pxl_out !== '0) begin
            n_fail++;
            $display("FAIL reset_pxl_out: got %0d expected 0", pxl_out);
        end
        mon_en = 1;
    endtask

    task automatic test_identity();
        int p0, l0;
        kern_drv = 72'h0;
        kern_drv[4*8 +: 8] = 8'd1;
        p0 = pulse_cnt;
        l0 = last_cnt;
        ramp(25, 1'b1);
        drain();
        n_checks += 3;
        if (pulse_cnt - p0 != 9) begin
            n_fail++;
            $display("FAIL identity_pulses: got %0d expected 9", pulse_cnt - p0);
        end
        if (last_cnt - l0 != 1) begin
            n_fail++;
            $display("FAIL identity_last_count: got %0d expected 1", last_cnt - l0);
        end
        if (pxl_out !== 21'sd18) begin
            n_fail++;
            $display("FAIL identity_final: got %0d expected 18", pxl_out);
        end
    endtask

    task automatic test_gaps();
        int p0;
        kern_drv = kern_all(8'd1);
        p0 = pulse_cnt;
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, i == 0, 8'd2);
            drive(1'b0, 1'b0, 8'd2);
        end
        drain();
        n_checks += 2;
        if (pulse_cnt - p0 != 9) begin
            n_fail++;
            $display("FAIL gaps_pulses: got %0d expected 9", pulse_cnt - p0);
        end
        if (pxl_out !== 21'sd18) begin
            n_fail++;
            $display("FAIL gaps_final: got %0d expected 18", pxl_out);
        end
    endtask

    task automatic test_negative();
        int p0;
        logic signed [AW-1:0] want;
`ifdef CONV3X3_RELU_EN
        want = '0;
`else
        want = -21'sd2295;
`endif
        kern_drv = kern_all(8'hFF);
        p0 = pulse_cnt;
        for (int i = 0; i < 25; i++) drive(1'b1, i == 0, 8'd255);
        drain();
        n_checks += 2;
        if (pulse_cnt - p0 != 9) begin
            n_fail++;
            $display("FAIL negative_pulses: got %0d expected 9", pulse_cnt - p0);
        end
        if (pxl_out !== want) begin
            n_fail++;
            $display("FAIL negative_final: got %0d expected %0d", pxl_out, want);
        end
    endtask

    task automatic test_reset_midframe();
        int p0;
        kern_drv = 72'h0;
        kern_drv[4*8 +: 8] = 8'd1;
        ramp(14, 1'b1);
        do_reset(2);
        p0 = pulse_cnt;
        ramp(25, 1'b1);
        drain();
        n_checks += 2;
        if (pulse_cnt - p0 != 9) begin
            n_fail++;
            $display("FAIL midreset_pulses: got %0d expected 9", pulse_cnt - p0);
        end
        if (pxl_out !== 21'sd18) begin
            n_fail++;
            $display("FAIL midreset_final: got %0d expected 18", pxl_out);
        end
    endtask

    task automatic test_resync();
        int p0, l0;
        kern_drv = 72'h0;
        kern_drv[4*8 +: 8] = 8'd1;
        ramp(7, 1'b1);
        p0 = pulse_cnt;
        l0 = last_cnt;
        ramp(25, 1'b1);
        drain();
        n_checks += 2;
        if (pulse_cnt - p0 != 9) begin
            n_fail++;
            $display("FAIL resync_pulses: got %0d expected 9", pulse_cnt - p0);
        end
        if (last_cnt - l0 != 1) begin
            n_fail++;
            $display("FAIL resync_last_count: got %0d expected 1", last_cnt - l0);
        end
    endtask

    task automatic test_kernel_change();
        int p0;
        p0 = pulse_cnt;
        for (int f = 0; f < 2; f++) begin
            kern_drv = kern_rand();
            for (int i = 0; i < 25; i++) begin
                if (i == 8 + f) kern_drv = kern_rand();
                drive(1'b1, i == 0, 8'($urandom_range(0, 255)));
            end
        end
        drain();
        n_checks++;
        if (pulse_cnt - p0 != 18) begin
            n_fail++;
            $display("FAIL kchange_pulses: got %0d expected 18", pulse_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        int p0, l0, sent;
        do_reset(1);
        p0 = pulse_cnt;
        l0 = last_cnt;
        sent = 0;
        while (sent < 75) begin
            kern_drv = kern_rand();
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
            end else begin
                drive(1'b1, 1'b0, 8'($urandom_range(0, 255)));
                sent++;
            end
        end
        drain();
        n_checks += 3;
        if (pulse_cnt - p0 != 27) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d expected 27", pulse_cnt - p0);
        end
        if (last_cnt - l0 != 3) begin
            n_fail++;
            $display("FAIL b2b_last_count: got %0d expected 3", last_cnt - l0);
        end
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_pending: got %0d outstanding expected 0", q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        pxl_valid = 1'b0;
        sof       = 1'b0;
        pxl_in    = '0;
        kern_drv  = '0;
        kernel    = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_identity();
        test_gaps();
        test_negative();
        test_reset_midframe();
        test_resync();
        test_kernel_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 SHALL have parameter IMG_W, default 16, pixels per image row (>=3).
REQ-002 SHALL have parameter IMG_H, default 16, rows per frame (>=3).
REQ-003 SHALL have parameter DATA_W, default 8, unsigned pixel width.
REQ-004 SHALL have parameter COEF_W, default 8, signed two's-complement coefficient width.
REQ-005 SHALL have localparam ACC_W = DATA_W+COEF_W+5, signed result width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pxl_in  input  DATA_W  raster-order pixel.
REQ-009 pxl_valid  input  1  pxl_in accepted on any clk edge where high; gaps allowed.
REQ-010 sof  input  1  start of frame, qualified by pxl_valid; marks row 0, col 0.
REQ-011 kernel  input  9*COEF_W  coefficients k00..k22; k00 in LSBs, row-major.
REQ-012 pxl_out  output  ACC_W  signed convolution result.
REQ-013 out_valid  output  1  pxl_out holds a valid window result this cycle.
REQ-014 out_last  output  1  with out_valid, marks the last window of a frame.

Function
REQ-015 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters; each advances only on an accepted pixel.
REQ-016 col SHALL wrap IMG_W-1->0 and increment row; row SHALL wrap IMG_H-1->0 (implicit new frame).
REQ-017 sof with pxl_valid SHALL force that pixel to row 0, col 0, whatever the counter state (mid-frame resync).
REQ-018 SHALL buffer the two previous rows in two IMG_W-deep line buffers, written only on accepted pixels.
REQ-019 SHALL form the 3x3 window from rows row-2..row and cols col-2..col; window valid only when row>=2 and col>=2.
REQ-020 Result SHALL be sum(kij * pixel(row-2+i, col-2+j)), pixels zero-extended, products signed, full precision, no overflow.
REQ-021 Pipeline SHALL be two registered stages (9 products, then adder tree); result appears exactly 2 clk cycles after the accepted pixel completing the window, independent of later pxl_valid gaps.
REQ-022 out_valid SHALL pulse for exactly one cycle per valid window: (IMG_W-2)*(IMG_H-2) pulses per frame.
REQ-023 out_last SHALL assert only with the window at row IMG_H-1, col IMG_W-1.
REQ-024 kernel SHALL be captured into an internal register on each accepted sof pixel and on the first accepted pixel after reset; coefficient changes at other times SHALL NOT affect results.
REQ-025 pxl_out SHALL hold its last value while out_valid is low.

Reset
REQ-026 On reset: row=0, col=0, pipeline valids cleared, out_valid=0, out_last=0, pxl_out=0, kernel register=0.
REQ-027 Line buffer contents need not be cleared; no window using pre-reset data SHALL produce out_valid.
REQ-028 Reset mid-frame SHALL discard in-flight results; the first accepted pixel after reset is row 0, col 0.

Configuration
REQ-029 Macro CONV3X3_RELU_EN: when defined, stage-2 output SHALL clamp negative results to 0 (ReLU); when undefined, pxl_out SHALL carry the signed result unchanged. Latency is 2 cycles in both builds.

Verification (IMG_W=5, IMG_H=5)
REQ-030 Identity kernel (k11=1, others 0), pixels 0..24 with sof on pixel 0 -> pxl_out 6,7,8,11,12,13,16,17,18; out_last only with 18; 9 out_valid pulses.
REQ-031 All-ones kernel, constant pixel 2, pxl_valid toggling 1/0 every cycle -> nine results of 18, each 2 cycles after its completing pixel.
REQ-032 All-coef -1, constant pixel 255 -> pxl_out -2295 without CONV3X3_RELU_EN; 0 with it.
REQ-033 Reset asserted after pixel 13 then ramp restarted with sof -> no out_valid before the new frame's row 2 col 2; then 6,7,8,... as REQ-030.
REQ-034 sof asserted at pixel 7 of a frame, then 25-pixel ramp -> counters resync; outputs match REQ-030 exactly.
REQ-035 Kernel changed mid-frame (no sof) -> results use the coefficients captured at sof until the next sof.
